// File: rtl/mandelbrot_iter_ctrl.sv
// Per-pixel Mandelbrot iteration sequencer sharing one external registered
// fixed-point multiplier: z <- z^2 + c from z=0, returns the escape count.
module mandelbrot_iter_ctrl #(
  parameter  int unsigned RW       = 4,
  parameter  int unsigned IW       = 28,
  parameter  int unsigned MAX_ITER = 255,
  localparam int unsigned W        = RW + IW,
  localparam int unsigned ITW      = $clog2(MAX_ITER + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] c_re,
  input  logic signed [W-1:0] c_im,
  input  logic                abort,
  output logic [W-1:0]        mult_a,
  output logic [W-1:0]        mult_b,
  input  logic signed [W-1:0] mult_o,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [ITW-1:0]      res_iter,
  output logic                res_escaped,
  output logic                busy
);

  localparam int unsigned SW = W + 1;
  localparam logic signed [W-1:0]  LIM2 = W'(64'd2 << IW);
  localparam logic signed [SW-1:0] LIM4 = SW'(64'd4 << IW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQR,
    S_SQI,
    S_CRS,
    S_UPD,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [W-1:0] r_cre, r_cim, r_zr, r_zi, r_rr, r_ii;
  logic [ITW-1:0]      r_iter, r_res_iter;
  logic                r_res_valid, r_res_escaped;

  logic                w_accept, w_cap_rr, w_cap_ii, w_upd, w_go_done, w_esc, w_kill;
  logic                w_z_big;
  logic signed [SW-1:0] w_rr_x, w_ii_x, w_s;
  logic signed [W-1:0] w_zr_new, w_zi_new;
  logic [ITW-1:0]      w_iter_inc, w_res_iter_nxt;

  // Iteration arithmetic; the |z|<2 gate in SQR keeps every term in range
  assign w_z_big    = (r_zr >= LIM2) || (r_zr <= -LIM2) ||
                      (r_zi >= LIM2) || (r_zi <= -LIM2);
  assign w_rr_x     = {r_rr[W-1], r_rr};
  assign w_ii_x     = {r_ii[W-1], r_ii};
  assign w_s        = w_rr_x + w_ii_x;
  assign w_zr_new   = r_rr - r_ii + r_cre;
  assign w_zi_new   = (mult_o <<< 1) + r_cim;
  assign w_iter_inc = r_iter + ITW'(1);
  assign w_kill     = abort && (r_state != S_IDLE);

  assign in_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign res_valid   = r_res_valid;
  assign res_iter    = r_res_iter;
  assign res_escaped = r_res_escaped;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state, multiplier operand selection and datapath strobes
  always_comb begin
    w_state_nxt    = r_state;
    mult_a         = '0;
    mult_b         = '0;
    w_accept       = 1'b0;
    w_cap_rr       = 1'b0;
    w_cap_ii       = 1'b0;
    w_upd          = 1'b0;
    w_go_done      = 1'b0;
    w_esc          = 1'b0;
    w_res_iter_nxt = r_iter;
    case (r_state)
      S_IDLE: begin
        if (in_valid && !abort) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SQR;
        end
      end
      S_SQR: begin
        if (w_z_big) begin
          w_go_done   = 1'b1;
          w_esc       = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          mult_a      = r_zr;
          mult_b      = r_zr;
          w_state_nxt = S_SQI;
        end
      end
      S_SQI: begin
        mult_a      = r_zi;
        mult_b      = r_zi;
        w_cap_rr    = 1'b1;
        w_state_nxt = S_CRS;
      end
      S_CRS: begin
        mult_a      = r_zr;
        mult_b      = r_zi;
        w_cap_ii    = 1'b1;
        w_state_nxt = S_UPD;
      end
      S_UPD: begin
        if (w_s > LIM4) begin
          w_go_done   = 1'b1;
          w_esc       = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_upd = 1'b1;
          if (w_iter_inc == ITW'(MAX_ITER)) begin
            w_go_done      = 1'b1;
            w_res_iter_nxt = w_iter_inc;
            w_state_nxt    = S_DONE;
          end else begin
            w_state_nxt = S_SQR;
          end
        end
      end
      S_DONE: begin
        if (res_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_kill) begin
      w_state_nxt = S_IDLE;
      w_go_done   = 1'b0;
    end
  end

  // Point, z and partial-product registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cre  <= '0;
      r_cim  <= '0;
      r_zr   <= '0;
      r_zi   <= '0;
      r_rr   <= '0;
      r_ii   <= '0;
      r_iter <= '0;
    end else begin
      if (w_accept) begin
        r_cre  <= c_re;
        r_cim  <= c_im;
        r_zr   <= '0;
        r_zi   <= '0;
        r_iter <= '0;
      end
      if (w_cap_rr) r_rr <= mult_o;
      if (w_cap_ii) r_ii <= mult_o;
      if (w_upd) begin
        r_zr   <= w_zr_new;
        r_zi   <= w_zi_new;
        r_iter <= w_iter_inc;
      end
    end
  end

  // Result holding registers; abort drops the pixel without a result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid   <= 1'b0;
      r_res_iter    <= '0;
      r_res_escaped <= 1'b0;
    end else if (w_kill) begin
      r_res_valid <= 1'b0;
    end else if (w_go_done) begin
      r_res_valid   <= 1'b1;
      r_res_iter    <= w_res_iter_nxt;
      r_res_escaped <= w_esc;
    end else if ((r_state == S_DONE) && res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

endmodule
